// File: rtl/accel_bus_pkg.sv
// Shared definitions for the accelerator bus master.
//   Register addresses of the accelerator and the encoding of the
//   job-sequencing FSM states.
package accel_bus_pkg;

   localparam logic [3:0] ADDR_N0    = 4'd0;
   localparam logic [3:0] ADDR_N1    = 4'd1;
   localparam logic [3:0] ADDR_N2    = 4'd2;
   localparam logic [3:0] ADDR_N3    = 4'd3;
   localparam logic [3:0] ADDR_START = 4'd5;
   localparam logic [3:0] ADDR_INTEN = 4'd6;
   localparam logic [3:0] ADDR_DONE  = 4'd7;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_WR_N,
      ST_WR_INTEN,
      ST_WR_START,
      ST_WAIT,
      ST_RD_RES,
      ST_RD_DONE,
      ST_WR_CLR,
      ST_RESP
   } state_t;

endpackage

// File: rtl/accel_bus_access.sv
// Single-access bus engine.
//   start/rd/addr/wdata : command, accepted only while idle (busy=0)
//   busy                : an access is in flight (cs=1)
//   done                : memDataReady seen this cycle; rdata valid now
//   timeout             : access ran TIMEOUT cycles without memDataReady
//   cs/readmem/writemem/address/bus_wdata : registered bus drive
// After done or timeout cs drops for at least one cycle, which gives the
// mandatory idle cycle between consecutive accesses.
module accel_bus_access #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              rd,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic              timeout,
   output logic [DATA_W-1:0] rdata,
   output logic              cs,
   output logic              readmem,
   output logic              writemem,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              mem_data_ready
);

   localparam int            CW      = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TO_LOAD = CW'(TIMEOUT - 1);

   logic              cs_q, cs_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_q    <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         cs_q    <= cs_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
      end
   end

   // address/data only load when idle, so they never move while cs=1
   always_comb begin
      cs_d    = cs_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      if (!cs_q) begin
         if (start) begin
            cs_d    = 1'b1;
            rd_d    = rd;
            wr_d    = !rd;
            addr_d  = addr;
            wdata_d = wdata;
            cnt_d   = TO_LOAD;
         end
      end else if (mem_data_ready || cnt_q == '0) begin
         cs_d = 1'b0;
         rd_d = 1'b0;
         wr_d = 1'b0;
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   assign busy      = cs_q;
   assign done      = cs_q & mem_data_ready;
   assign timeout   = cs_q & !mem_data_ready & (cnt_q == '0);
   assign rdata     = bus_rdata;
   assign cs        = cs_q;
   assign readmem   = rd_q;
   assign writemem  = wr_q;
   assign address   = addr_q;
   assign bus_wdata = wdata_q;

endmodule

// File: rtl/accel_host_master.sv
// Accelerator host master: accepts a job (operand n), programs the
// accelerator, waits for completion (interrupt or DONE polling), reads the
// 32-bit result, clears DONE and returns the result on a valid/ready port.
//   req_valid/req_ready/req_n            : job request
//   resp_valid/resp_ready/resp_result/resp_err : job response
//   cs/readmem/writemem/address/bus_wdata/bus_rdata/memDataReady : bus
//   interrupt                            : accelerator completion (level)
//
// state        | meaning
// ST_IDLE      | ready for a job
// ST_WR_N      | write operand to addr 0
// ST_WR_INTEN  | write interrupt enable (USE_IRQ) to addr 6
// ST_WR_START  | write 0 to START (addr 5)
// ST_WAIT      | wait for interrupt, or poll DONE (addr 7)
// ST_RD_RES    | read result bytes 0..3
// ST_RD_DONE   | read DONE (addr 7)
// ST_WR_CLR    | write 0 to DONE
// ST_RESP      | hold response until accepted
module accel_host_master
   import accel_bus_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 4,
   parameter int USE_IRQ = 1,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [7:0]        req_n,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_result,
   output logic              resp_err,
   output logic              cs,
   output logic              readmem,
   output logic              writemem,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              memDataReady,
   input  logic              interrupt
);

   localparam int            CW        = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] WAIT_LOAD = CW'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic [7:0]    n_q, n_d;
   logic [31:0]   result_q, result_d;
   logic          err_q, err_d;
   logic [1:0]    idx_q, idx_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          issued_q, issued_d;
   logic          req_ready_q, req_ready_d;
   logic          resp_valid_q, resp_valid_d;

   logic              acc_start, acc_rd, acc_busy, acc_done, acc_timeout;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata, acc_rdata;
   logic              want_access;

   accel_bus_access #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .TIMEOUT(TIMEOUT)
   ) u_access (
      .clk           (clk),
      .rst           (rst),
      .start         (acc_start),
      .rd            (acc_rd),
      .addr          (acc_addr),
      .wdata         (acc_wdata),
      .busy          (acc_busy),
      .done          (acc_done),
      .timeout       (acc_timeout),
      .rdata         (acc_rdata),
      .cs            (cs),
      .readmem       (readmem),
      .writemem      (writemem),
      .address       (address),
      .bus_wdata     (bus_wdata),
      .bus_rdata     (bus_rdata),
      .mem_data_ready(memDataReady)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         n_q          <= '0;
         result_q     <= '0;
         err_q        <= 1'b0;
         idx_q        <= '0;
         wait_cnt_q   <= '0;
         issued_q     <= 1'b0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         n_q          <= n_d;
         result_q     <= result_d;
         err_q        <= err_d;
         idx_q        <= idx_d;
         wait_cnt_q   <= wait_cnt_d;
         issued_q     <= issued_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      result_d   = result_q;
      err_d      = err_q;
      idx_d      = idx_q;
      wait_cnt_d = wait_cnt_q;
      if (acc_timeout) begin
         state_d  = ST_RESP;
         result_d = '0;
         err_d    = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: if (req_valid && req_ready_q) begin
               state_d  = ST_WR_N;
               n_d      = req_n;
               result_d = '0;
               err_d    = 1'b0;
               idx_d    = '0;
            end
            ST_WR_N:     if (acc_done) state_d = ST_WR_INTEN;
            ST_WR_INTEN: if (acc_done) state_d = ST_WR_START;
            ST_WR_START: if (acc_done) begin
               state_d    = ST_WAIT;
               wait_cnt_d = WAIT_LOAD;
            end
            ST_WAIT: begin
               if (wait_cnt_q != '0) wait_cnt_d = wait_cnt_q - 1'b1;
               if (USE_IRQ != 0) begin
                  if (interrupt) state_d = ST_RD_RES;
                  else if (wait_cnt_q == '0) begin
                     state_d  = ST_RESP;
                     result_d = '0;
                     err_d    = 1'b1;
                  end
               end else if (acc_done) begin
                  if (acc_rdata[0]) state_d = ST_RD_RES;
               end else if (!issued_q && wait_cnt_q == '0) begin
                  // only give up between polls so no access is cut short
                  state_d  = ST_RESP;
                  result_d = '0;
                  err_d    = 1'b1;
               end
            end
            ST_RD_RES: if (acc_done) begin
               // byte 0 arrives first and shifts down to the LSB
               result_d = {acc_rdata[7:0], result_q[31:8]};
               idx_d    = idx_q + 1'b1;
               if (idx_q == 2'd3) state_d = ST_RD_DONE;
            end
            ST_RD_DONE: if (acc_done) state_d = ST_WR_CLR;
            ST_WR_CLR:  if (acc_done) state_d = ST_RESP;
            ST_RESP:    if (resp_ready && resp_valid_q) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
         endcase
      end
      req_ready_d  = (state_d == ST_IDLE);
      resp_valid_d = (state_d == ST_RESP);
   end

   always_comb begin
      want_access = 1'b0;
      acc_rd      = 1'b0;
      acc_addr    = ADDR_W'(ADDR_N0);
      acc_wdata   = '0;
      case (state_q)
         ST_WR_N: begin
            want_access = 1'b1;
            acc_wdata   = DATA_W'(n_q);
         end
         ST_WR_INTEN: begin
            want_access = 1'b1;
            acc_addr    = ADDR_W'(ADDR_INTEN);
            acc_wdata   = DATA_W'(USE_IRQ != 0);
         end
         ST_WR_START: begin
            want_access = 1'b1;
            acc_addr    = ADDR_W'(ADDR_START);
         end
         ST_WAIT: begin
            want_access = (USE_IRQ == 0);
            acc_rd      = 1'b1;
            acc_addr    = ADDR_W'(ADDR_DONE);
         end
         ST_RD_RES: begin
            want_access = 1'b1;
            acc_rd      = 1'b1;
            acc_addr    = ADDR_W'(idx_q);
         end
         ST_RD_DONE: begin
            want_access = 1'b1;
            acc_rd      = 1'b1;
            acc_addr    = ADDR_W'(ADDR_DONE);
         end
         ST_WR_CLR: begin
            want_access = 1'b1;
            acc_addr    = ADDR_W'(ADDR_DONE);
         end
         default: want_access = 1'b0;
      endcase
      acc_start = want_access & !issued_q & !acc_busy;
      issued_d  = (issued_q | acc_start) & !(acc_done | acc_timeout);
   end

   assign req_ready   = req_ready_q;
   assign resp_valid  = resp_valid_q;
   assign resp_result = result_q;
   assign resp_err    = err_q;

endmodule

// File: tb/tb_accel_host_master.sv
// Directed bench for accel_host_master. Two instances share clock/reset:
// index 0 runs in interrupt mode (TIMEOUT=16), index 1 in polling mode.
// A behavioural accelerator per instance answers the bus and logs every
// completed access as {W,000,addr,data}.
module tb_accel_host_master;

   logic clk, rst;
   logic       req_valid_w [2], req_ready_w [2], resp_valid_w [2], resp_ready_w [2];
   logic       resp_err_w [2], cs_w [2], rd_w [2], wr_w [2], mdr_w [2], irq_w [2];
   logic [7:0] req_n_w [2], wdata_w [2], rdata_w [2];
   logic [3:0] addr_w [2];
   logic [31:0] result_w [2];

   logic [15:0] trace [2][32];
   int          tcnt [2], wcnt [2], pcnt [2], stab_err [2];
   logic        pcs [2], prd [2], pwr [2];
   logic [3:0]  paddr [2];
   logic [7:0]  pwd [2];
   int          w5_cycles;
   logic        clr_trace, stall_w5, hold_irq;
   int          wait_n;
   logic [31:0] model_result;
   logic [15:0] exp_tr [16];
   int          n_assert = 0, n_fail = 0;

   accel_host_master #(.DATA_W(8), .ADDR_W(4), .USE_IRQ(1), .TIMEOUT(16)) dut_irq (
      .clk(clk), .rst(rst),
      .req_valid(req_valid_w[0]), .req_ready(req_ready_w[0]), .req_n(req_n_w[0]),
      .resp_valid(resp_valid_w[0]), .resp_ready(resp_ready_w[0]),
      .resp_result(result_w[0]), .resp_err(resp_err_w[0]),
      .cs(cs_w[0]), .readmem(rd_w[0]), .writemem(wr_w[0]), .address(addr_w[0]),
      .bus_wdata(wdata_w[0]), .bus_rdata(rdata_w[0]),
      .memDataReady(mdr_w[0]), .interrupt(irq_w[0]));

   accel_host_master #(.DATA_W(8), .ADDR_W(4), .USE_IRQ(0), .TIMEOUT(64)) dut_poll (
      .clk(clk), .rst(rst),
      .req_valid(req_valid_w[1]), .req_ready(req_ready_w[1]), .req_n(req_n_w[1]),
      .resp_valid(resp_valid_w[1]), .resp_ready(resp_ready_w[1]),
      .resp_result(result_w[1]), .resp_err(resp_err_w[1]),
      .cs(cs_w[1]), .readmem(rd_w[1]), .writemem(wr_w[1]), .address(addr_w[1]),
      .bus_wdata(wdata_w[1]), .bus_rdata(rdata_w[1]),
      .memDataReady(mdr_w[1]), .interrupt(irq_w[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] model_rd(input int i, input logic [3:0] a);
      logic [31:0] r;
      r = model_result;
      if (a < 4'd4) return r[8*a +: 8];
      if (a == 4'd7) return (i == 0) ? {7'd0, irq_w[0]} : {7'd0, pcnt[1] >= 5};
      return 8'h00;
   endfunction

   // accelerator model: memDataReady after wait_n extra cycles
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         mdr_w[i] <= 1'b0;
         if (clr_trace) tcnt[i] <= 0;
         if (rst) begin
            irq_w[i] <= 1'b0;
            pcnt[i]  <= 0;
            wcnt[i]  <= 0;
         end else if (cs_w[i] && !mdr_w[i] &&
                      !(i == 0 && stall_w5 && wr_w[i] && addr_w[i] == 4'd5)) begin
            if (wcnt[i] >= wait_n) begin
               mdr_w[i] <= 1'b1;
               wcnt[i]  <= 0;
               if (rd_w[i]) begin
                  rdata_w[i] <= model_rd(i, addr_w[i]);
                  trace[i][tcnt[i] % 32] <= {4'h0, addr_w[i], model_rd(i, addr_w[i])};
                  if (addr_w[i] == 4'd7) pcnt[i] <= pcnt[i] + 1;
               end else begin
                  trace[i][tcnt[i] % 32] <= {4'h8, addr_w[i], wdata_w[i]};
                  if (addr_w[i] == 4'd5 && !hold_irq) irq_w[i] <= 1'b1;
                  if (addr_w[i] == 4'd7) begin
                     irq_w[i] <= 1'b0;
                     pcnt[i]  <= 0;
                  end
               end
               if (!clr_trace) tcnt[i] <= tcnt[i] + 1;
            end else begin
               wcnt[i] <= wcnt[i] + 1;
            end
         end
      end
   end

   // bus stability watcher
   always @(negedge clk) begin
      if (clr_trace) w5_cycles <= 0;
      else if (cs_w[0] && wr_w[0] && addr_w[0] == 4'd5) w5_cycles <= w5_cycles + 1;
      for (int i = 0; i < 2; i++) begin
         if (clr_trace) stab_err[i] <= 0;
         else if ((rd_w[i] && wr_w[i]) ||
                  (cs_w[i] && pcs[i] && (addr_w[i] != paddr[i] || wdata_w[i] != pwd[i] ||
                                         rd_w[i] != prd[i] || wr_w[i] != pwr[i])))
            stab_err[i] <= stab_err[i] + 1;
         pcs[i]   <= cs_w[i];
         prd[i]   <= rd_w[i];
         pwr[i]   <= wr_w[i];
         paddr[i] <= addr_w[i];
         pwd[i]   <= wdata_w[i];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      #1 clr_trace = 1'b1;
      @(negedge clk);
      #1 clr_trace = 1'b0;
   endtask

   task automatic send_req(input int i, input logic [7:0] n);
      int t = 0;
      req_n_w[i]     = n;
      req_valid_w[i] = 1'b1;
      while (req_ready_w[i] !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("req_accept", 32'(req_ready_w[i]), 32'd1);
      @(negedge clk);
      req_valid_w[i] = 1'b0;
   endtask

   task automatic wait_resp(input int i, input int budget);
      int t = 0;
      while (resp_valid_w[i] !== 1'b1 && t < budget) begin
         @(negedge clk);
         t++;
      end
      chk("resp_valid_seen", 32'(resp_valid_w[i]), 32'd1);
   endtask

   task automatic consume(input int i);
      resp_ready_w[i] = 1'b1;
      @(negedge clk);
      resp_ready_w[i] = 1'b0;
      chk("resp_dropped", 32'(resp_valid_w[i]), 32'd0);
      chk("idle_req_ready", 32'(req_ready_w[i]), 32'd1);
   endtask

   task automatic check_trace(input int i, input int len);
      chk("trace_len", 32'(tcnt[i]), 32'(len));
      for (int k = 0; k < len && k < 16; k++)
         chk($sformatf("trace_%0d_%0d", i, k), 32'(trace[i][k]), 32'(exp_tr[k]));
   endtask

   initial begin
      int  t;
      logic seen;
      rst = 1'b1;
      clr_trace = 1'b1;
      stall_w5 = 1'b0;
      hold_irq = 1'b0;
      wait_n = 0;
      model_result = 32'h12345678;
      for (int i = 0; i < 2; i++) begin
         req_valid_w[i]  = 1'b0;
         resp_ready_w[i] = 1'b0;
         req_n_w[i]      = 8'h00;
      end

      // reset state
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("reset_outs", 32'({cs_w[i], rd_w[i], wr_w[i], addr_w[i], wdata_w[i],
                                req_ready_w[i], resp_valid_w[i], resp_err_w[i]}), 32'd0);
         chk("reset_result", result_w[i], 32'd0);
      end
      rst = 1'b0;
      clr_trace = 1'b0;
      #1 chk("req_ready_at_release", 32'(req_ready_w[0]), 32'd0);
      @(negedge clk);
      chk("req_ready_after_release", 32'(req_ready_w[0]), 32'd1);
      chk("req_ready_after_release_poll", 32'(req_ready_w[1]), 32'd1);

      // irq mode, zero-wait accelerator
      exp_tr = '{0: 16'h800A, 1: 16'h8601, 2: 16'h8500, 3: 16'h0078, 4: 16'h0156,
                 5: 16'h0234, 6: 16'h0312, 7: 16'h0701, 8: 16'h8700, default: 16'h0000};
      clear_log();
      send_req(0, 8'h0A);
      wait_resp(0, 200);
      chk("irq_result", result_w[0], 32'h12345678);
      chk("irq_err", 32'(resp_err_w[0]), 32'd0);
      check_trace(0, 9);
      chk("irq_bus_stable", 32'(stab_err[0]), 32'd0);
      consume(0);

      // irq mode, 3 wait cycles per access
      clear_log();
      wait_n = 3;
      send_req(0, 8'h0A);
      wait_resp(0, 400);
      chk("wait_result", result_w[0], 32'h12345678);
      chk("wait_err", 32'(resp_err_w[0]), 32'd0);
      check_trace(0, 9);
      chk("wait_bus_stable", 32'(stab_err[0]), 32'd0);
      consume(0);
      wait_n = 0;

      // polling mode, DONE on the 6th poll
      exp_tr = '{0: 16'h8021, 1: 16'h8600, 2: 16'h8500, 3: 16'h0700, 4: 16'h0700,
                 5: 16'h0700, 6: 16'h0700, 7: 16'h0700, 8: 16'h0701, 9: 16'h0078,
                 10: 16'h0156, 11: 16'h0234, 12: 16'h0312, 13: 16'h0701, 14: 16'h8700,
                 default: 16'h0000};
      clear_log();
      send_req(1, 8'h21);
      wait_resp(1, 400);
      chk("poll_result", result_w[1], 32'h12345678);
      chk("poll_err", 32'(resp_err_w[1]), 32'd0);
      check_trace(1, 15);
      chk("poll_bus_stable", 32'(stab_err[1]), 32'd0);
      consume(1);

      // START write never acknowledged -> abort
      exp_tr = '{0: 16'h8033, 1: 16'h8601, default: 16'h0000};
      clear_log();
      stall_w5 = 1'b1;
      send_req(0, 8'h33);
      wait_resp(0, 200);
      chk("abort_err", 32'(resp_err_w[0]), 32'd1);
      chk("abort_result", result_w[0], 32'd0);
      chk("abort_cs", 32'(cs_w[0]), 32'd0);
      chk("abort_w5_cycles", 32'(w5_cycles), 32'd16);
      check_trace(0, 2);
      consume(0);
      stall_w5 = 1'b0;

      // back-pressure and requests while busy
      clear_log();
      send_req(0, 8'h44);
      req_n_w[0]     = 8'h99;
      req_valid_w[0] = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("busy_req_ready", 32'(req_ready_w[0]), 32'd0);
      end
      wait_resp(0, 200);
      repeat (10) begin
         @(negedge clk);
         chk("hold_valid", 32'(resp_valid_w[0]), 32'd1);
         chk("hold_result", result_w[0], 32'h12345678);
         chk("hold_req_ready", 32'(req_ready_w[0]), 32'd0);
      end
      req_valid_w[0] = 1'b0;
      consume(0);
      chk("hold_trace_len", 32'(tcnt[0]), 32'd9);
      chk("hold_trace_n", 32'(trace[0][0]), 32'h8044);

      // reset while waiting for completion
      clear_log();
      hold_irq = 1'b1;
      send_req(0, 8'h55);
      t = 0;
      while (tcnt[0] < 3 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("midwait_reached", 32'(tcnt[0]), 32'd3);
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1 chk("midwait_rst_cs", 32'({cs_w[0], rd_w[0], wr_w[0]}), 32'd0);
      chk("midwait_rst_resp", 32'(resp_valid_w[0]), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      hold_irq = 1'b0;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (resp_valid_w[0] !== 1'b0 || cs_w[0] !== 1'b0) seen = 1'b1;
      end
      chk("midwait_no_resp", 32'(seen), 32'd0);
      chk("midwait_req_ready", 32'(req_ready_w[0]), 32'd1);
      chk("midwait_trace_len", 32'(tcnt[0]), 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
